adc_capture_seq: RTL
====================

// Module: adc_capture_seq
// PURPOSE
//  Sequences one ADC capture-and-dump cycle. Writes a run of decimated 12-bit samples into port A of the
//  capture dual-port RAM, then hands the frame to the RAM readout/UART path and waits for it to drain.
//  Sits between the ADC sample interface and the RAM readout controller; owns RAM port A.
// PARAMETERS
//  DATA_W   12        ADC sample width
//  ADDR_W   16        RAM address / length width
//  MAX_LEN  4096      max samples per frame; larger capture_len is clamped to this
//  DEC_W    8         decimation ratio width
// PORTS
//  clk           in   1       clock
//  rst           in   1       reset, asynchronous, active-high
//  start         in   1       1-cycle pulse: begin capture (ignored unless IDLE)
//  abort         in   1       level/pulse: cancel current operation
//  capture_len   in   ADDR_W  samples per frame, sampled at start
//  decim         in   DEC_W   keep 1 of every decim+1 valid samples, sampled at start
//  trig_level    in   DATA_W  trigger threshold (used only with CAPTURE_TRIG_EN)
//  sample_in     in   DATA_W  ADC sample
//  sample_valid  in   1       sample_in valid this cycle
//  ram_we        out  1       RAM port A write enable
//  ram_addr      out  ADDR_W  RAM port A address; 0 whenever ram_we=0
//  ram_din       out  16      {zero-pad, sample}
//  rd_start      out  1       1-cycle pulse to readout controller
//  rd_length     out  ADDR_W  samples written in frame; held stable from rd_start until DONE
//  rd_busy       in   1       readout controller active
//  busy          out  1       state != IDLE
//  done          out  1       1-cycle pulse: frame fully read out
//  aborted       out  1       1-cycle pulse: abort accepted
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; wr_ptr=1; decim counter 0.
//  - States: IDLE -> ARM -> CAPTURE -> HANDOFF -> DRAIN -> IDLE.
//  - IDLE: on start latch len=min(capture_len,MAX_LEN), dec=decim. len==0: done pulses next cycle, stay IDLE.
//  - ARM: see CONFIGURATION; without trigger, exits to CAPTURE in 1 cycle.
//  - CAPTURE: each sample_valid advances dec counter; kept sample when counter==0 (counter wraps at dec).
//    Kept sample -> next cycle ram_we=1, ram_addr=wr_ptr, ram_din={4'd0,sample_in}; wr_ptr++.
//    Addresses run 1..len; address 0 never written. Write latency 1 cycle, registered outputs.
//  - After address len is written -> HANDOFF; ram_we/ram_addr drop to 0 the following cycle.
//  - HANDOFF: rd_start=1 for exactly 1 cycle, rd_length=len -> DRAIN.
//  - DRAIN: wait for rd_busy high, then low; then done=1 for 1 cycle -> IDLE, wr_ptr=1.
//    rd_busy already high on entry counts as seen-high.
//  - abort: any non-IDLE state -> IDLE next cycle; ram_we=0, ram_addr=0 that cycle; aborted pulse;
//    no rd_start issued if not yet sent. Abort in IDLE is ignored. Abort and start in the same cycle: abort wins.
//  - start while busy is ignored. sample_valid outside CAPTURE/ARM is ignored.
// CONFIGURATION
//  CAPTURE_TRIG_EN defined:
//   - ARM compares consecutive valid samples (unsigned).
//   - Rising crossing (prev < trig_level && cur >= trig_level) -> that sample is the first kept sample;
//     decim counter starts at 0 on it.
//   - The first valid sample after start only loads prev and cannot trigger.
//  CAPTURE_TRIG_EN undefined:
//   - ARM lasts 1 cycle; trig_level is unused; the first valid sample in CAPTURE is kept.
// STRUCTURE
//  - Package adc_cap_pkg: state enum (IDLE, ARM, CAPTURE, HANDOFF, DRAIN), DATA_W/ADDR_W defaults, RAM pad width.
//  - Sub-module adc_trig_detect (prev-sample register + crossing compare), instantiated under CAPTURE_TRIG_EN.
//  - Remainder is a single FSM with address and decimation counters.
// TESTING
//  1. len=4, decim=0, continuous valid 0x100..0x103 -> writes addr 1..4 data 0x0100..0x0103,
//     rd_start once with rd_length=4.
//  2. len=3, decim=2, valid samples 0..8 -> samples 0,3,6 written to addr 1,2,3.
//  3. capture_len=5000 -> exactly 4096 writes, rd_length=4096; len=0 -> done pulse, no ram_we.
//  4. DRAIN: rd_busy high 10 cycles then low -> single done pulse 1 cycle after the fall; busy drops the same cycle.
//  5. abort after 2 writes -> aborted pulse, ram_we=0 the next cycle, no rd_start;
//     start+abort in IDLE -> no activity.
//  6. CAPTURE_TRIG_EN, trig=0x800, samples 0x7F0,0x7FF,0x800,0x900 -> first write is 0x0800 at addr 1.

Source files
------------

// File: rtl/adc_cap_pkg.sv
// Shared types and defaults for the ADC capture sequencer.
package adc_cap_pkg;

    localparam int unsigned DEF_DATA_W = 12;
    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned RAM_W      = 16;
    localparam int unsigned RAM_PAD_W  = RAM_W - DEF_DATA_W;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        CAPTURE,
        HANDOFF,
        DRAIN
    } cap_state_e;

endpackage

// File: rtl/adc_capture_seq_if.sv
// Capture RAM port A plus readout-controller handshake.
// master: sequencer side, slave: RAM / readout side.
interface adc_capture_seq_if #(
    parameter int unsigned ADDR_W = adc_cap_pkg::DEF_ADDR_W
);

    logic                           ram_we;
    logic [ADDR_W-1:0]              ram_addr;
    logic [adc_cap_pkg::RAM_W-1:0]  ram_din;
    logic                           rd_start;
    logic [ADDR_W-1:0]              rd_length;
    logic                           rd_busy;

    modport master (
        output ram_we,
        output ram_addr,
        output ram_din,
        output rd_start,
        output rd_length,
        input  rd_busy
    );

    modport slave (
        input  ram_we,
        input  ram_addr,
        input  ram_din,
        input  rd_start,
        input  rd_length,
        output rd_busy
    );

endinterface

// File: rtl/adc_trig_detect.sv
// Rising-threshold crossing detector over consecutive valid samples.
// The first sample after clear only primes the previous-sample register.
module adc_trig_detect #(
    parameter int unsigned DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              enable,
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] level,
    output logic              fire
);

    logic [DATA_W-1:0] prev_q;
    logic              loaded_q;

    // Track the last valid sample seen while armed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q   <= '0;
            loaded_q <= 1'b0;
        end else if (clear) begin
            loaded_q <= 1'b0;
        end else if (enable) begin
            prev_q   <= sample;
            loaded_q <= 1'b1;
        end
    end

    assign fire = enable && loaded_q && (prev_q < level) && (sample >= level);

endmodule

// File: rtl/adc_capture_seq.sv
// ADC capture-and-dump sequencer: decimated capture into RAM port A, then
// hands the frame to the readout path and waits for it to drain.
// Optional build macro: CAPTURE_TRIG_EN (threshold trigger in ARM).
module adc_capture_seq
    import adc_cap_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned MAX_LEN = 4096,
    parameter int unsigned DEC_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] capture_len,
    input  logic [DEC_W-1:0]  decim,
    input  logic [DATA_W-1:0] trig_level,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    adc_capture_seq_if.master bus
);

    localparam logic [ADDR_W-1:0] MAX_LEN_A = ADDR_W'(MAX_LEN);

    cap_state_e        state_q, state_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [DEC_W-1:0]  dec_q, dec_d;
    logic [DEC_W-1:0]  dec_cnt_q, dec_cnt_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic              seen_q, seen_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [RAM_W-1:0]  ram_din_q, ram_din_d;
    logic              rd_start_q, rd_start_d;
    logic [ADDR_W-1:0] rd_length_q, rd_length_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;

    logic              keep;
    logic              start_acc;
    logic [ADDR_W-1:0] len_clamped;
    logic [DEC_W-1:0]  dec_cnt_adv;
    logic              trig_fire;

    assign start_acc   = (state_q == IDLE) && start && !abort;
    assign len_clamped = (capture_len > MAX_LEN_A) ? MAX_LEN_A : capture_len;
    assign dec_cnt_adv = (dec_cnt_q == dec_q) ? '0 : dec_cnt_q + DEC_W'(1);

`ifdef CAPTURE_TRIG_EN
    adc_trig_detect #(
        .DATA_W (DATA_W)
    ) u_trig (
        .clk    (clk),
        .rst    (rst),
        .clear  (start_acc),
        .enable ((state_q == ARM) && sample_valid),
        .sample (sample_in),
        .level  (trig_level),
        .fire   (trig_fire)
    );
`else
    logic unused_trig_level;
    assign unused_trig_level = ^trig_level;
    assign trig_fire         = 1'b0;
`endif

    // Next-state and registered-output decode.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        dec_d       = dec_q;
        dec_cnt_d   = dec_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        seen_d      = seen_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = '0;
        ram_din_d   = '0;
        rd_start_d  = 1'b0;
        rd_length_d = rd_length_q;
        done_d      = 1'b0;
        aborted_d   = 1'b0;
        keep        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_acc) begin
                    len_d     = len_clamped;
                    dec_d     = decim;
                    dec_cnt_d = '0;
                    wr_ptr_d  = ADDR_W'(1);
                    if (len_clamped == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ARM;
                    end
                end
            end
            ARM: begin
`ifdef CAPTURE_TRIG_EN
                // The crossing sample is the first kept one.
                if (trig_fire) begin
                    keep      = 1'b1;
                    dec_cnt_d = dec_cnt_adv;
                end
`else
                state_d   = CAPTURE;
                dec_cnt_d = '0;
`endif
            end
            CAPTURE: begin
                if (sample_valid) begin
                    keep      = (dec_cnt_q == '0);
                    dec_cnt_d = dec_cnt_adv;
                end
            end
            HANDOFF: begin
                state_d = DRAIN;
                seen_d  = 1'b0;
            end
            DRAIN: begin
                if (bus.rd_busy) begin
                    seen_d = 1'b1;
                end
                if (seen_q && !bus.rd_busy) begin
                    done_d   = 1'b1;
                    state_d  = IDLE;
                    wr_ptr_d = ADDR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Kept sample: one-cycle registered write, rd_start coincides with HANDOFF.
        if (keep) begin
            ram_we_d   = 1'b1;
            ram_addr_d = wr_ptr_q;
            ram_din_d  = RAM_W'(sample_in);
            wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
            if (wr_ptr_q == len_q) begin
                state_d     = HANDOFF;
                rd_start_d  = 1'b1;
                rd_length_d = len_q;
            end else begin
                state_d = CAPTURE;
            end
        end

        if (abort && (state_q != IDLE)) begin
            state_d    = IDLE;
            ram_we_d   = 1'b0;
            ram_addr_d = '0;
            ram_din_d  = '0;
            rd_start_d = 1'b0;
            done_d     = 1'b0;
            aborted_d  = 1'b1;
            wr_ptr_d   = ADDR_W'(1);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            dec_q       <= '0;
            dec_cnt_q   <= '0;
            wr_ptr_q    <= ADDR_W'(1);
            seen_q      <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            rd_start_q  <= 1'b0;
            rd_length_q <= '0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            dec_q       <= dec_d;
            dec_cnt_q   <= dec_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            seen_q      <= seen_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            rd_start_q  <= rd_start_d;
            rd_length_q <= rd_length_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_din   = ram_din_q;
    assign bus.rd_start  = rd_start_q;
    assign bus.rd_length = rd_length_q;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign aborted       = aborted_q;

endmodule
